// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: tracks in-flight register writes, stalls on RAW/WAW hazards,
// and sequences multi-cycle MUL/DIV occupancy of the shared ALU.
module issue_scoreboard #(
    parameter int unsigned REG_W      = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [REG_W-1:0]        id_src_a,
    input  logic [REG_W-1:0]        id_src_b,
    input  logic                    id_uses_b,
    input  logic [REG_W-1:0]        id_dest,
    input  logic                    id_reg_write,
    input  logic [2:0]              id_alu_op,
    input  logic                    wb_valid,
    input  logic [REG_W-1:0]        wb_dest,
    output logic                    issue,
    output logic                    stall,
    output logic                    ex_busy,
    output logic                    ex_done,
    output logic [(2**REG_W)-1:0]   pending
);

    localparam int unsigned DEPTH = 2**REG_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [2:0]  OP_MUL = 3'b100;
    localparam logic [2:0]  OP_DIV = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ex_done_q, ex_done_d;
    logic [DEPTH-1:0]   pending_q, pending_d;
    logic [DEPTH-1:0]   wb_hit;
    logic [DEPTH-1:0]   eff;
    logic               hazard;

    // Effective pending: a same-cycle write-back resolves the hazard (write-through RF)
    always_comb begin
        wb_hit = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            wb_hit[r] = wb_valid && (wb_dest == REG_W'(r));
        end
        eff    = pending_q & ~wb_hit;
        eff[0] = 1'b0;
        hazard = eff[id_src_a] | (id_uses_b & eff[id_src_b]) | (id_reg_write & eff[id_dest]);
    end

    // Scoreboard next state: set beats clear on the same register
    always_comb begin
        pending_d = pending_q & ~wb_hit;
        if (issue && id_reg_write && (id_dest != '0)) begin
            pending_d[id_dest] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ex_done_q <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_done_q <= ex_done_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ex_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue && (id_alu_op == OP_MUL)) begin
                    cnt_d   = CNT_W'(MUL_CYCLES - 1);
                    state_d = S_BUSY;
                end else if (issue && (id_alu_op == OP_DIV)) begin
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = S_IDLE;
                    ex_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        issue   = id_valid & ~hazard & (state_q == S_IDLE);
        stall   = id_valid & ~issue;
        ex_busy = (state_q == S_BUSY);
        ex_done = ex_done_q;
        pending = pending_q;
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized + directed bench for issue_scoreboard against a behavioural model
// that tracks pending registers as an array and EX occupancy as a remaining-cycle count.
module tb_issue_scoreboard;

    localparam int unsigned REG_W = 4;
    localparam int unsigned MUL_N = 4;
    localparam int unsigned DIV_N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_src_a, id_src_b, id_dest;
    logic        id_uses_b, id_reg_write;
    logic [2:0]  id_alu_op;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic        issue, stall, ex_busy, ex_done;
    logic [15:0] pending;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bit pend_m [16];
    int busy_rem = 0;
    bit done_m = 1'b0;

    issue_scoreboard #(.REG_W(REG_W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_uses_b(id_uses_b), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_alu_op(id_alu_op), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .issue(issue), .stall(stall), .ex_busy(ex_busy), .ex_done(ex_done),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit eff_m(input logic [3:0] r);
        return (r != 4'd0) && pend_m[r] && !(wb_valid && wb_dest == r);
    endfunction

    function automatic bit exp_issue();
        if (!id_valid || busy_rem != 0) return 1'b0;
        if (eff_m(id_src_a)) return 1'b0;
        if (id_uses_b && eff_m(id_src_b)) return 1'b0;
        if (id_reg_write && eff_m(id_dest)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] pend_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = pend_m[i];
        return v;
    endfunction

    // Reference model update
    initial begin
        for (int i = 0; i < 16; i++) pend_m[i] = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) pend_m[i] = 1'b0;
                busy_rem = 0;
                done_m   = 1'b0;
            end else begin
                bit iss;
                iss = exp_issue();
                if (wb_valid) pend_m[wb_dest] = 1'b0;
                if (iss && id_reg_write && id_dest != 4'd0) pend_m[id_dest] = 1'b1;
                done_m = 1'b0;
                if (busy_rem > 0) begin
                    busy_rem--;
                    if (busy_rem == 0) done_m = 1'b1;
                end
                if (iss && id_alu_op == 3'b100) busy_rem = int'(MUL_N) - 1;
                else if (iss && id_alu_op == 3'b101) busy_rem = int'(DIV_N) - 1;
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("issue",   32'(issue),   32'(exp_issue()));
                chk("stall",   32'(stall),   32'(id_valid & ~exp_issue()));
                chk("ex_busy", 32'(ex_busy), 32'(busy_rem != 0));
                chk("ex_done", 32'(ex_done), 32'(done_m));
                chk("pending", 32'(pending), 32'(pend_vec()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ub,
                          input logic [3:0] d, input logic rw, input logic [2:0] op);
        id_valid = v; id_src_a = a; id_src_b = b; id_uses_b = ub;
        id_dest = d; id_reg_write = rw; id_alu_op = op;
    endtask

    task automatic set_wb(input logic v, input logic [3:0] d);
        wb_valid = v; wb_dest = d;
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_wb(1'b0, 4'd0);
        chk_en = 1'b1;
        #2;
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_busy",    32'(ex_busy), 32'h0);
        chk("rst_done",    32'(ex_done), 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;

        // add r3 = r1 + r2, then write-back of r3
        tick(); set_id(1, 4'd1, 4'd2, 1, 4'd3, 1, 3'b000); #1 chk("add_issue", 32'(issue), 32'h1);
        tick(); idle(); chk("add_pend", 32'(pending), 32'h0008);
        tick();
        tick(); set_wb(1, 4'd3);
        tick(); set_wb(0, 4'd0); chk("add_wb_clear", 32'(pending), 32'h0);

        // RAW: sub r4 = r3 - r1 waits for r3 write-back, issues in that cycle
        tick(); set_id(1, 4'd1, 4'd2, 1, 4'd3, 1, 3'b000);
        tick(); set_id(1, 4'd3, 4'd1, 1, 4'd4, 1, 3'b001); #1 chk("raw_stall0", 32'(stall), 32'h1);
        tick(); #1 chk("raw_stall1", 32'(stall), 32'h1);
        tick(); set_wb(1, 4'd3); #1 chk("raw_issue", 32'(issue), 32'h1); chk("raw_nostall", 32'(stall), 32'h0);
        tick(); idle(); set_wb(0, 4'd0); chk("raw_pend", 32'(pending), 32'h0010);
        tick(); set_wb(1, 4'd4);
        tick(); set_wb(0, 4'd0);

        // MUL r5 then xor r6 blocked until ex_done
        tick(); set_id(1, 4'd1, 4'd2, 1, 4'd5, 1, 3'b100); #1 chk("mul_issue", 32'(issue), 32'h1);
        tick(); set_id(1, 4'd1, 4'd2, 1, 4'd6, 1, 3'b110);
        #1 chk("mul_busy1", 32'(ex_busy), 32'h1); chk("mul_stall1", 32'(stall), 32'h1);
        tick(); chk("mul_busy2", 32'(ex_busy), 32'h1);
        tick(); #1 chk("mul_busy3", 32'(ex_busy), 32'h1); chk("mul_stall3", 32'(stall), 32'h1);
        tick(); #1 chk("mul_done", 32'(ex_done), 32'h1); chk("mul_idle", 32'(ex_busy), 32'h0);
        chk("xor_issue", 32'(issue), 32'h1);
        tick(); idle(); chk("mul_done_pulse", 32'(ex_done), 32'h0); chk("mul_pend", 32'(pending), 32'h0060);
        set_wb(1, 4'd5);
        tick(); set_wb(1, 4'd6);
        tick(); set_wb(0, 4'd0); chk("mul_wb_clear", 32'(pending), 32'h0);

        // r0 as source and destination never stalls nor goes pending
        tick(); set_id(1, 4'd0, 4'd0, 1, 4'd0, 1, 3'b000); #1 chk("r0_issue0", 32'(issue), 32'h1);
        tick(); #1 chk("r0_issue1", 32'(issue), 32'h1); chk("r0_pend", 32'(pending), 32'h0);

        // Same-cycle set and clear on r7: set wins
        tick(); set_id(1, 4'd1, 4'd2, 1, 4'd7, 1, 3'b000); set_wb(1, 4'd7); #1 chk("r7_issue0", 32'(issue), 32'h1);
        tick(); #1 chk("r7_pend0", 32'(pending), 32'h0080); chk("r7_issue1", 32'(issue), 32'h1);
        tick(); idle(); set_wb(0, 4'd0); chk("r7_pend1", 32'(pending), 32'h0080);
        tick(); set_wb(1, 4'd7);
        tick(); set_wb(0, 4'd0); chk("r7_clear", 32'(pending), 32'h0);

        // DIV abandoned by reset mid-op
        tick(); set_id(1, 4'd1, 4'd2, 1, 4'd8, 1, 3'b101); #1 chk("div_issue", 32'(issue), 32'h1);
        tick(); idle();
        tick();
        tick(); chk("div_busy", 32'(ex_busy), 32'h1); chk("div_pend", 32'(pending), 32'h0100);
        #1 rst_n = 1'b0;
        #1 chk("div_rst_busy", 32'(ex_busy), 32'h0); chk("div_rst_done", 32'(ex_done), 32'h0);
        chk("div_rst_pend", 32'(pending), 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        tick(); set_id(1, 4'd1, 4'd2, 1, 4'd3, 1, 3'b000); #1 chk("post_rst_issue", 32'(issue), 32'h1);
        tick(); idle(); set_wb(1, 4'd3);
        tick(); set_wb(0, 4'd0);

        // Randomized traffic, biased toward hazards and useful write-backs
        for (int c = 0; c < 1500; c++) begin
            int plist [$];
            tick();
            id_valid     = ($urandom_range(0, 9) < 8);
            id_src_a     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
            id_src_b     = 4'($urandom_range(0, 7));
            id_uses_b    = 1'($urandom_range(0, 1));
            id_dest      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
            id_reg_write = ($urandom_range(0, 4) != 0);
            id_alu_op    = 3'($urandom_range(0, 6));
            for (int i = 0; i < 16; i++) if (pend_m[i]) plist.push_back(i);
            wb_valid = 1'($urandom_range(0, 1));
            if (plist.size() > 0 && $urandom_range(0, 3) != 0)
                wb_dest = 4'(plist[$urandom_range(0, plist.size() - 1)]);
            else
                wb_dest = 4'($urandom_range(0, 15));
        end

        tick(); idle(); set_wb(0, 4'd0);
        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
